dll_lock_reset_sequencer: RTL

- Sits directly downstream of the 24.576 MHz DLL clock-generation stage and runs on its buffered 2x system clock (49.152 MHz).
- Synchronizes both DLL lock indicators and requires continuous lock for a hold period before releasing resets.
- Releases the system reset first and the peripheral reset a fixed gap later.
- On loss of either lock, re-asserts resets, counts the event, waits a holdoff period and re-arms.

---
 rtl/dll_lock_reset_sequencer_pkg.sv | 40 ++++
 rtl/dll_lock_reset_sequencer_sync_bit_n.sv | 27 ++
 rtl/dll_lock_reset_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dll_lock_reset_sequencer_pkg.sv
// Shared definitions for the DLL lock / reset release sequencer:
// state encodings, default parameter values and constant helper functions.
package dll_lock_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_REL_CORE  = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } seq_state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_HOLD_CYCLES   = 4096;
  localparam int DEF_STAGE_GAP     = 16;
  localparam int DEF_RETRY_HOLDOFF = 1024;
  localparam int DEF_CNT_W         = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end
    if (c > m) begin
      m = c;
    end
    return m;
  endfunction

endpackage

// File: rtl/dll_lock_reset_sequencer_sync_bit_n.sv
// Single-bit multi-flop synchronizer with a synchronous active-low reset.
// Used to bring each asynchronous DLL lock flag into the clk domain.
module sync_bit_n
  import dll_lock_reset_sequencer_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic ares_L,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift chain; d enters at bit 0 and the synchronized value leaves at the top.
  always_ff @(posedge clk) begin
    if (!ares_L) begin
      chain_r <= {STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/dll_lock_reset_sequencer.sv
// Releases core and peripheral resets after both DLLs show a sustained lock,
// and re-asserts them (with a counted event and a retry holdoff) on lock loss.
module dll_lock_reset_sequencer
  import dll_lock_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP     = DEF_STAGE_GAP,
  parameter int RETRY_HOLDOFF = DEF_RETRY_HOLDOFF,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             ares_L,
  input  logic             dll0_locked_async,
  input  logic             dll1_locked_async,
  input  logic             lost_cnt_clr,
  output logic             sys_rst_L,
  output logic             periph_rst_L,
  output logic             clocks_good,
  output logic             lock_lost_pulse,
  output logic [CNT_W-1:0] lock_lost_count,
  output logic [2:0]       seq_state
);

  localparam int CW_RAW = clog2(max3(HOLD_CYCLES, STAGE_GAP, RETRY_HOLDOFF));
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [CW-1:0]    CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE      = CW'(32'd1);
  localparam logic [CW-1:0]    HOLD_LAST    = CW'(HOLD_CYCLES - 32'sd1);
  localparam logic [CW-1:0]    GAP_LAST     = CW'(STAGE_GAP - 32'sd1);
  localparam logic [CW-1:0]    HOLDOFF_LAST = CW'(RETRY_HOLDOFF - 32'sd1);
  localparam logic [CNT_W-1:0] EVT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] EVT_ONE      = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] EVT_MAX      = {CNT_W{1'b1}};

  logic             dll0_sync_s;
  logic             dll1_sync_s;
  logic             locked_both_s;
  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic             loss_event_s;
  logic             sys_rst_nxt_s;
  logic             periph_rst_nxt_s;
  logic             clocks_good_nxt_s;
  logic [CNT_W-1:0] lost_cnt_nxt_s;

  sync_bit_n #(.STAGES(SYNC_STAGES)) u_sync_dll0 (
    .clk    (clk),
    .ares_L (ares_L),
    .d      (dll0_locked_async),
    .q      (dll0_sync_s)
  );

  sync_bit_n #(.STAGES(SYNC_STAGES)) u_sync_dll1 (
    .clk    (clk),
    .ares_L (ares_L),
    .d      (dll1_locked_async),
    .q      (dll1_sync_s)
  );

  assign locked_both_s = dll0_sync_s & dll1_sync_s;

  // Next-state and phase counter; every state leaves at terminal count so cnt never wraps.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    loss_event_s = 1'b0;
    case (state_r)
      ST_WAIT_LOCK: begin
        cnt_nxt_s = CNT_ZERO;
        if (locked_both_s) begin
          state_nxt_s = ST_STABLE;
        end else begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        // Dropping lock before resets are released is simply a restart.
        if (!locked_both_s) begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == HOLD_LAST) begin
          state_nxt_s = ST_REL_CORE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_REL_CORE: begin
        if (!locked_both_s) begin
          state_nxt_s  = ST_LOST;
          cnt_nxt_s    = CNT_ZERO;
          loss_event_s = 1'b1;
        end else if (cnt_r == GAP_LAST) begin
          state_nxt_s  = ST_RUN;
          cnt_nxt_s    = CNT_ZERO;
        end else begin
          cnt_nxt_s    = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        cnt_nxt_s = CNT_ZERO;
        if (!locked_both_s) begin
          state_nxt_s  = ST_LOST;
          loss_event_s = 1'b1;
        end else begin
          state_nxt_s  = ST_RUN;
        end
      end
      ST_LOST: begin
        if (cnt_r == HOLDOFF_LAST) begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT_LOCK;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state, plus the saturating loss counter.
  always_comb begin
    sys_rst_nxt_s     = (state_nxt_s == ST_REL_CORE) || (state_nxt_s == ST_RUN);
    periph_rst_nxt_s  = (state_nxt_s == ST_RUN);
    clocks_good_nxt_s = (state_nxt_s == ST_RUN);
    lost_cnt_nxt_s    = lock_lost_count;
    // A clear coinciding with a loss still records that loss.
    if (loss_event_s) begin
      if (lost_cnt_clr) begin
        lost_cnt_nxt_s = EVT_ONE;
      end else if (lock_lost_count == EVT_MAX) begin
        lost_cnt_nxt_s = EVT_MAX;
      end else begin
        lost_cnt_nxt_s = lock_lost_count + EVT_ONE;
      end
    end else if (lost_cnt_clr) begin
      lost_cnt_nxt_s = EVT_ZERO;
    end else begin
      lost_cnt_nxt_s = lock_lost_count;
    end
  end

  // State, counter and registered outputs all update on the same edge.
  always_ff @(posedge clk) begin
    if (!ares_L) begin
      state_r         <= ST_WAIT_LOCK;
      cnt_r           <= CNT_ZERO;
      sys_rst_L       <= 1'b0;
      periph_rst_L    <= 1'b0;
      clocks_good     <= 1'b0;
      lock_lost_pulse <= 1'b0;
      lock_lost_count <= EVT_ZERO;
    end else begin
      state_r         <= state_nxt_s;
      cnt_r           <= cnt_nxt_s;
      sys_rst_L       <= sys_rst_nxt_s;
      periph_rst_L    <= periph_rst_nxt_s;
      clocks_good     <= clocks_good_nxt_s;
      lock_lost_pulse <= loss_event_s;
      lock_lost_count <= lost_cnt_nxt_s;
    end
  end

  assign seq_state = state_r;

endmodule
